// File: rtl/tape_fetch_pkg.sv
// tape_fetch_pkg: FSM encoding, address width and default prefetch depth
// shared by the tape fetch path.
package tape_fetch_pkg;
    localparam int AW = 23;
    localparam int FIFO_DEPTH_DEF = 8;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, ABORTING} state_t;
endpackage

// File: rtl/tape_fetch_if.sv
// tape_fetch_if: SDRAM tape port plus byte stream output; master is the fetcher.
interface tape_fetch_if;
    import tape_fetch_pkg::*;
    logic [AW-1:0] tape_addr;
    logic          tape_rd;
    logic [7:0]    tape_dout;
    logic          tape_ack;
    logic [7:0]    dout;
    logic          dout_valid;
    logic          dout_ready;
    modport master (output tape_addr, tape_rd, dout, dout_valid, input tape_dout, tape_ack, dout_ready);
    modport slave (input tape_addr, tape_rd, dout, dout_valid, output tape_dout, tape_ack, dout_ready);
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: prefetch byte FIFO; push on full is accepted when a pop happens
// in the same cycle, pop on empty is ignored.
module byte_fifo #(
    parameter int DEPTH = tape_fetch_pkg::FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [PW:0] wp, rp;
    logic do_push, do_pop;
    assign count = wp - rp;
    assign empty = count == '0;
    assign full = count == (PW+1)'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign dout = empty ? 8'h00 : mem[rp[PW-1:0]];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else if (clear) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (PW+1)'(do_push);
            rp <= rp + (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push && !clear) mem[wp[PW-1:0]] <= din;
endmodule

// File: rtl/tape_fetch.sv
// tape_fetch: streams a byte range out of SDRAM through a toggle-ack tape port
// into a small prefetch FIFO, one outstanding request at a time.
module tape_fetch
    import tape_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] length,
    tape_fetch_if.master  bus,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] fetched
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state, nxt;
    logic [AW-1:0] base, len;
    logic ack_seen, draining, ack_tog, last, would_full, pop_fire;
    logic start_ok, issue, push, clear, done_nxt;
    logic full, empty;
    logic [CW-1:0] count;
    assign ack_tog = bus.tape_ack != ack_seen;
    assign pop_fire = bus.dout_ready & ~empty;
    assign last = (fetched + AW'(1)) == len;
    assign would_full = ~pop_fire & (count == CW'(FIFO_DEPTH - 1));
    assign bus.dout_valid = ~empty;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = (start_ok && length != '0) ? FETCH : IDLE;
            FETCH:    nxt = abort ? IDLE : WAIT;
            WAIT:     nxt = ack_tog ? ((abort || last) ? IDLE : would_full ? HOLD : FETCH)
                                    : (abort ? ABORTING : WAIT);
            HOLD:     nxt = abort ? IDLE : (!full ? FETCH : HOLD);
            ABORTING: nxt = ack_tog ? IDLE : ABORTING;
            default:  nxt = IDLE;
        endcase
    end
    always_comb begin
        start_ok = state == IDLE && start && !abort && !draining;
        issue = state == FETCH && !abort;
        push = state == WAIT && ack_tog && !abort;
        clear = start_ok || (abort && state inside {IDLE, FETCH, HOLD})
              || (ack_tog && (state == ABORTING || (state == WAIT && abort)));
        done_nxt = (start_ok && length == '0) || (draining && pop_fire && count == CW'(1) && !abort);
        busy = state != IDLE || draining;
    end
    // draining keeps the stream busy after the last fetch until the FIFO empties
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base <= '0;
            len <= '0;
            fetched <= '0;
            ack_seen <= 1'b0;
            draining <= 1'b0;
            done <= 1'b0;
            bus.tape_rd <= 1'b0;
            bus.tape_addr <= '0;
        end else begin
            ack_seen <= (state == WAIT || state == ABORTING) ? ack_seen : bus.tape_ack;
            done <= done_nxt;
            draining <= (push && last) || (draining && !done_nxt && !abort);
            fetched <= start_ok ? '0 : fetched + AW'(push);
            if (start_ok) begin
                base <= base_addr;
                len <= length;
            end
            if (issue) begin
                bus.tape_rd <= 1'b1;
                bus.tape_addr <= base + fetched;
            end else if (ack_tog && (state == WAIT || state == ABORTING)) begin
                bus.tape_rd <= 1'b0;
            end
        end
    end
    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .clear(clear),
        .push(push),
        .pop(bus.dout_ready),
        .din(bus.tape_dout),
        .dout(bus.dout),
        .full(full),
        .empty(empty),
        .count(count)
    );
endmodule
